// File: rtl/pll_mdrp_seq.sv
// Sequencer for the PLLA MD reconfiguration port: holds the PLL in reset, writes and
// verifies a register profile from an external table, then waits for a stable lock.
module pll_mdrp_seq #(
    parameter int PROF_W       = 1,
    parameter int IDX_W        = 5,
    parameter int NUM_REGS     = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 2000000,
    parameter int MAX_RETRY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PROF_W-1:0]       profile,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [PROF_W+IDX_W-1:0] tbl_addr,
    input  logic [15:0]             tbl_data,
    output logic                    pll_reset,
    input  logic                    pll_lock,
    output logic                    md_clk,
    output logic [1:0]              md_opc,
    output logic                    md_ainc,
    output logic [7:0]              md_wdi,
    input  logic [7:0]              md_rdo
);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_SETADDR, S_WRITE, S_RDADDR, S_READ,
        S_RELEASE, S_WAIT_LOCK, S_DONE, S_FAIL
    } state_t;

    state_t            state;
    logic [1:0]        ph;
    logic [PROF_W-1:0] prof;
    logic [IDX_W-1:0]  idx;
    logic [RW-1:0]     retry;
    logic [15:0]       data;
    logic              lock_meta, lock_sync;
    logic [SW-1:0]     stable;
    logic [TW-1:0]     tmo;

    assign md_ainc = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ph        <= '0;
            prof      <= '0;
            idx       <= '0;
            retry     <= '0;
            data      <= '0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            stable    <= '0;
            tmo       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
            tbl_addr  <= '0;
            pll_reset <= 1'b0;
            md_clk    <= 1'b0;
            md_opc    <= 2'b00;
            md_wdi    <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        prof      <= profile;
                        idx       <= '0;
                        retry     <= '0;
                        busy      <= 1'b1;
                        err_code  <= 2'b00;
                        pll_reset <= 1'b1;
                        tbl_addr  <= {profile, {IDX_W{1'b0}}};
                        ph        <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ph == 2'd0) begin
                        ph <= 2'd1;
                    end else begin
                        // First op is launched here so its C0 follows immediately.
                        data   <= tbl_data;
                        md_opc <= 2'b11;
                        md_wdi <= tbl_data[15:8];
                        ph     <= '0;
                        state  <= S_SETADDR;
                    end
                end
                S_SETADDR, S_WRITE, S_RDADDR, S_READ: begin
                    if (ph == 2'd0) begin
                        md_clk <= 1'b1;
                        ph     <= 2'd1;
                    end else if (ph == 2'd1) begin
                        md_clk <= 1'b0;
                        md_opc <= 2'b00;
                        ph     <= 2'd2;
                    end else begin
                        ph <= '0;
                        case (state)
                            S_SETADDR: begin
                                md_opc <= 2'b01;
                                md_wdi <= data[7:0];
                                state  <= S_WRITE;
                            end
                            S_WRITE: begin
                                md_opc <= 2'b11;
                                md_wdi <= data[15:8];
                                state  <= S_RDADDR;
                            end
                            S_RDADDR: begin
                                md_opc <= 2'b10;
                                state  <= S_READ;
                            end
                            default: begin
                                // Readback check folded into the end of C2, keeping 14 cycles per entry.
                                if (md_rdo != data[7:0]) begin
                                    err_code <= 2'b01;
                                    state    <= S_FAIL;
                                end else if (idx == IDX_W'(NUM_REGS - 1)) begin
                                    state <= S_RELEASE;
                                end else begin
                                    idx      <= idx + IDX_W'(1);
                                    tbl_addr <= {prof, idx + IDX_W'(1)};
                                    state    <= S_FETCH;
                                end
                            end
                        endcase
                    end
                end
                S_RELEASE: begin
                    pll_reset <= 1'b0;
                    stable    <= '0;
                    tmo       <= '0;
                    state     <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (!lock_sync)
                        stable <= '0;
                    else if (stable != SW'(LOCK_STABLE))
                        stable <= stable + SW'(1);
                    if (tmo != TW'(LOCK_TIMEOUT))
                        tmo <= tmo + TW'(1);
                    if (lock_sync && stable == SW'(LOCK_STABLE - 1)) begin
                        state <= S_DONE;
                    end else if (tmo == TW'(LOCK_TIMEOUT - 1)) begin
                        err_code <= 2'b10;
                        state    <= S_FAIL;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAIL: begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry     <= retry + RW'(1);
                        idx       <= '0;
                        tbl_addr  <= {prof, {IDX_W{1'b0}}};
                        pll_reset <= 1'b1;
                        ph        <= '0;
                        state     <= S_FETCH;
                    end else begin
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        pll_reset <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_mdrp_seq.sv
// Directed self-checking bench for pll_mdrp_seq with a table ROM and an echoing MD register model.
module tb_pll_mdrp_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [0:0]  profile = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data = '0;
    logic        pll_reset;
    logic        pll_lock = 1'b0;
    logic        md_clk;
    logic [1:0]  md_opc;
    logic        md_ainc;
    logic [7:0]  md_wdi;
    logic [7:0]  md_rdo = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_mdrp_seq #(
        .PROF_W(1), .IDX_W(5), .NUM_REGS(16), .LOCK_STABLE(1024),
        .LOCK_TIMEOUT(5000), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .profile(profile),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .pll_reset(pll_reset),
        .pll_lock(pll_lock), .md_clk(md_clk), .md_opc(md_opc), .md_ainc(md_ainc),
        .md_wdi(md_wdi), .md_rdo(md_rdo)
    );

    // Table: profile 0 entry i = {0x12+i, 0x0B+i}; profile 1 entry i = {0x40+i, 0xA0+i}.
    function automatic logic [15:0] rom(input logic [5:0] a);
        logic [7:0] i8;
        i8 = {3'b000, a[4:0]};
        if (a[5]) return {8'h40 + i8, 8'hA0 + i8};
        return {8'h12 + i8, 8'h0B + i8};
    endfunction

    always @(posedge clk) tbl_data <= rom(tbl_addr);

    // PLL MD register model; corrupt forces 0xFF on the readback of address 0x15 (entry 3).
    logic [7:0] regs [256];
    logic [7:0] cur = '0;
    logic       corrupt = 1'b0;
    logic [9:0] trace[$];
    int writes = 0;
    int ops_unreset = 0;

    always @(posedge md_clk) begin
        trace.push_back({md_opc, md_wdi});
        if (!pll_reset) ops_unreset <= ops_unreset + 1;
        case (md_opc)
            2'b11: cur <= md_wdi;
            2'b01: begin
                regs[cur] <= md_wdi;
                writes    <= writes + 1;
            end
            2'b10: md_rdo <= (corrupt && cur == 8'h15) ? 8'hFF : regs[cur];
            default: ;
        endcase
    end

    int   done_cnt = 0, err_cnt = 0, msb_seen = 0, md_bad = 0;
    logic prev_mdclk = 1'b0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (busy && tbl_addr[5]) msb_seen <= msb_seen + 1;
        if ((prev_mdclk && md_clk) || (prev_mdclk && !md_clk && md_opc != 2'b00) || md_ainc)
            md_bad <= md_bad + 1;
        prev_mdclk <= md_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic p);
        profile = p;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        while (pll_reset && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, pll_reset}, 32'd0);
    endtask

    task automatic wait_end(input int budget, output int n);
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, d0, e0, w0;
        logic [31:0] exp_e;
        logic [7:0]  i8;

        tick(3);
        check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_tbl_addr", {26'd0, tbl_addr}, 32'd0);
        check("rst_md", {20'd0, pll_reset, md_clk, md_opc, md_ainc, md_wdi}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Nominal run with an ignored mid-sequence start on profile 1.
        trace.delete();
        d0 = done_cnt;
        pulse_start(1'b0);
        tick(2);
        check("nom_busy_reset", {30'd0, busy, pll_reset}, 32'd3);
        tick(40);
        pulse_start(1'b1);
        profile = 1'b0;
        wait_release("nom_release");
        check("nom_trace_len", trace.size(), 32'd64);
        for (int i = 0; i < 16; i++) begin
            i8 = 8'(i);
            exp_e = {2'b11, 8'h12 + i8, 2'b01, 8'h0B + i8, 2'b11, 8'h12 + i8, 2'b10};
            check($sformatf("nom_trace_e%0d", i),
                  {trace[4*i], trace[4*i+1], trace[4*i+2], trace[4*i+3][9:8]}, exp_e);
        end
        tick(500);
        pll_lock = 1'b1;
        wait_end(3000, n);
        check("nom_done_latency", n, 32'd1027);
        check("nom_err_code", {30'd0, err_code}, 32'd0);
        tick(3);
        check("nom_single_done", done_cnt - d0, 32'd1);
        check("nom_profile_msb", msb_seen, 32'd0);
        check("nom_idle", {30'd0, busy, pll_reset}, 32'd0);

        // Lock glitch restarts the stable count.
        pll_lock = 1'b0;
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_release("gl_release");
        tick(10);
        pll_lock = 1'b1;
        tick(800);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        check("gl_no_early_done", done_cnt - d0, 32'd0);
        wait_end(3000, n);
        check("gl_done_latency", n, 32'd1027);
        check("gl_done", {31'd0, done}, 32'd1);

        // Readback mismatch on entry 3 every pass.
        pll_lock = 1'b0;
        corrupt  = 1'b1;
        w0 = writes;
        e0 = err_cnt;
        pulse_start(1'b0);
        wait_end(3000, n);
        check("rb_error", {31'd0, error}, 32'd1);
        check("rb_err_code", {30'd0, err_code}, 32'd1);
        check("rb_idle", {30'd0, busy, pll_reset}, 32'd0);
        check("rb_writes", writes - w0, 32'd12);
        tick(3);
        check("rb_single_error", err_cnt - e0, 32'd1);
        corrupt = 1'b0;

        // Lock never asserted: timeout on every pass.
        w0 = writes;
        e0 = err_cnt;
        pulse_start(1'b0);
        wait_end(20000, n);
        check("to_error", {31'd0, error}, 32'd1);
        check("to_err_code", {30'd0, err_code}, 32'd2);
        check("to_idle", {30'd0, busy, pll_reset}, 32'd0);
        check("to_writes", writes - w0, 32'd48);
        tick(3);
        check("to_single_error", err_cnt - e0, 32'd1);

        // Reset during WRITE C1, then a clean rerun.
        pulse_start(1'b0);
        n = 0;
        while (!(md_clk && md_opc == 2'b01) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rs_write_c1_seen", {31'd0, md_clk}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_outputs", {27'd0, md_clk, md_opc, pll_reset, busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        pulse_start(1'b0);
        wait_release("rs_release");
        tick(20);
        pll_lock = 1'b1;
        wait_end(3000, n);
        check("rs_done", {31'd0, done}, 32'd1);
        check("rs_err_code", {30'd0, err_code}, 32'd0);

        tick(2);
        check("md_protocol", md_bad, 32'd0);
        check("md_ops_out_of_reset", ops_unreset, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pll_mdrp_seq.md
Name: pll_mdrp_seq

Overview:
- Sequencer for the PLLA dynamic-reconfiguration (MD) port.
- On a start pulse it:
  - holds the PLL in reset;
  - streams a selected profile of register address/value pairs from an external table through MDCLK/MDOPC/MDAINC/MDWDI;
  - reads each register back over MDRDO and compares it;
  - releases reset and waits for a stable lock.
- Sits between the video-mode control logic and the PLL wrapper, so the pixel/serial clocks (e.g. 74.25/371.25 MHz vs 148.5/742.5 MHz) can be retargeted at runtime.

Parameters:
- PROF_W, 1, width of profile select; table holds 2^PROF_W profiles.
- IDX_W, 5, width of per-profile entry index.
- NUM_REGS, 16, entries written per profile (1..2^IDX_W).
- LOCK_STABLE, 1024, consecutive clk cycles pll_lock must stay high before done.
- LOCK_TIMEOUT, 2000000, clk cycles allowed from reset release to stable lock.
- MAX_RETRY, 2, full-sequence retries after a readback or timeout failure.

Ports:
- clk  in  1  controller clock; also source of md_clk.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; ignored while busy.
- profile  in  PROF_W  profile to load; sampled on an accepted start.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on final failure.
- err_code  out  2  last result: 00 ok, 01 readback mismatch, 10 lock timeout; held until next start.
- tbl_addr  out  PROF_W+IDX_W  {profile, index} to the external table ROM.
- tbl_data  in  16  [15:8] MD register address, [7:0] value; valid 1 cycle after tbl_addr.
- pll_reset  out  1  to PLL RESET, active-high.
- pll_lock  in  1  PLL LOCK (asynchronous; 2-flop synchronised internally).
- md_clk  out  1  PLL MDCLK.
- md_opc  out  2  PLL MDOPC: 00 nop, 01 write, 10 read, 11 load address from MDWDI.
- md_ainc  out  1  PLL MDAINC; tied 0 by this block (explicit addressing).
- md_wdi  out  8  PLL MDWDI.
- md_rdo  in  8  PLL MDRDO.

Behaviour:
- Reset values: busy=0, done=0, error=0, err_code=00, tbl_addr=0, pll_reset=0, md_clk=0, md_opc=00, md_ainc=0, md_wdi=0. pll_reset=0 lets the PLL run its static configuration.
- MD op timing, 3 clk cycles per op:
  - C0: md_clk=0, md_opc/md_wdi driven.
  - C1: md_clk=1, same values held; the PLL samples on this rising edge.
  - C2: md_clk=0, md_opc=00.
  - md_clk is 0 whenever no op is active.
- Read result: md_rdo is sampled at the end of C2 of the read op.
- States:
  - IDLE: start=1 → latch profile, idx=0, retry=0, busy=1, err_code=00, pll_reset=1 → FETCH.
  - FETCH: drive tbl_addr={profile,idx}; wait 1 cycle; register tbl_data → SETADDR.
  - SETADDR: op 11 with md_wdi=tbl_data[15:8] → WRITE.
  - WRITE: op 01 with md_wdi=tbl_data[7:0] → RDADDR.
  - RDADDR: op 11 with the same address → READ.
  - READ: op 10, capture md_rdo → CHECK.
  - CHECK:
    - mismatch → FAIL(01).
    - idx==NUM_REGS-1 → RELEASE.
    - else idx+1 → FETCH.
  - RELEASE: pll_reset=0, clear lock and timeout counters → WAIT_LOCK.
  - WAIT_LOCK:
    - Synchronised lock high increments the stable counter; lock low clears it.
    - Stable counter reaching LOCK_STABLE → DONE.
    - Timeout counter reaching LOCK_TIMEOUT → FAIL(10).
  - DONE: done=1 for 1 cycle, busy=0 → IDLE.
  - FAIL:
    - retry<MAX_RETRY: retry+1, idx=0, pll_reset=1 → FETCH; err_code updated, no error pulse.
    - else error=1 for 1 cycle, busy=0, pll_reset=0 → IDLE.
- start while busy is ignored; profile changes while busy are ignored.
- Lock loss after DONE is not monitored.
- pll_reset is held high from start acceptance through the last CHECK, including across retries.
- Counters are sized by $clog2 of their limits; they saturate and never wrap.
- rst_n low in any state returns all outputs to reset values within the same edge, ending any MD op with md_clk=0 and md_opc=00. PLL register contents may then be partial; a new start is required.
- Latency with zero retries: 1 + NUM_REGS×14 (2 fetch + 4 ops×3) cycles to RELEASE, plus the lock phase.

Test Plan:
- Nominal, profile=0, table idx0={0x12,0x0B}, 16 entries, PLL model echoes writes, lock rises 500 cycles after release → MD trace shows 11/0x12, 01/0x0B, 11/0x12, 10 for each entry; done pulses exactly 1024 cycles after lock is stable; err_code=00; pll_reset low after the last CHECK.
- Readback mismatch: model returns 0xFF for entry 3 on every pass → 3 sequences are run (MAX_RETRY=2); error pulses once; err_code=01; pll_reset=0; busy=0.
- Lock glitch: lock high 800 cycles, low 1 cycle, then high → stable counter restarts; done at glitch+1+1024 cycles (plus synchroniser delay).
- Lock timeout with LOCK_TIMEOUT=5000 and lock never asserted → two retries, then error; err_code=10.
- start pulsed mid-sequence with profile=1 → ignored; tbl_addr MSB stays 0; a single done.
- rst_n low during a WRITE op C1 → next cycle md_clk=0, md_opc=00, pll_reset=0, busy=0; a fresh start completes normally.
